// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3) for the display path.
// Optional macro BCD_BLANK_EN adds the leading-zero blank mask output.
module bin2bcd_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int INT_DIGITS = WIDTH * 3 / 10 + 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BW = 4 * INT_DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    bin_sr_q, bin_sr_d;
    logic [BW-1:0]       bcd_sr_q, bcd_sr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       adj;
    logic                load_res;

    logic [4*DIGITS-1:0] bcd_q;
    logic                ovf_q;
    logic                out_valid_q;
    logic [4*DIGITS-1:0] res_bcd;
    logic                res_ovf;

    // Final digits come from the shift register as it will be after the last shift.
    if (DIGITS < INT_DIGITS) begin : g_trunc
        assign res_bcd = bcd_sr_d[4*DIGITS-1:0];
        assign res_ovf = |bcd_sr_d[BW-1:4*DIGITS];
    end else begin : g_wide
        assign res_bcd = (4*DIGITS)'(bcd_sr_d);
        assign res_ovf = 1'b0;
    end

    // Next-state, datapath shifting and result-load strobe.
    always_comb begin
        state_d  = state_q;
        bin_sr_d = bin_sr_q;
        bcd_sr_d = bcd_sr_q;
        cnt_d    = cnt_q;
        load_res = 1'b0;
        adj      = bcd_sr_q;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_sr_d = in_data;
                    bcd_sr_d = '0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_sr_d, bin_sr_d} = {adj, bin_sr_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d    = '0;
                    load_res = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, shift registers and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bin_sr_q <= '0;
            bcd_sr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            bin_sr_q <= bin_sr_d;
            bcd_sr_q <= bcd_sr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Result registers only move when a conversion completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= load_res;
            if (load_res) begin
                bcd_q <= res_bcd;
                ovf_q <= res_ovf;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;
    assign ovf       = ovf_q;

`ifdef BCD_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    logic [DIGITS-1:0] blank_q, blank_d;
    logic              zrun;

    // Digit i blanks when it and every higher digit are zero; digit 0 never blanks.
    always_comb begin
        blank_d = '0;
        zrun    = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zrun       = zrun & (res_bcd[4*i +: 4] == 4'd0);
            blank_d[i] = zrun & ~res_ovf;
        end
    end

    // Blank mask is registered alongside the digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= BLANK_RST;
        end else if (load_res) begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases plus random values
// against an arithmetic decimal model.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic [31:0] bcd;
    logic        ovf;
`ifdef BCD_BLANK_EN
    logic [7:0]  blank;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    bin2bcd_seq #(.WIDTH(32), .DIGITS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .bcd      (bcd),
        .ovf      (ovf)
`ifdef BCD_BLANK_EN
        ,
        .blank    (blank)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_bcd(input longint unsigned v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint unsigned v);
        return v >= 64'd100000000;
    endfunction

    function automatic logic [7:0] ref_blank(input longint unsigned v);
        logic [7:0] b;
        longint unsigned p;
        b = '0;
        p = 1;
        if (ref_ovf(v)) return b;
        for (int i = 1; i < 8; i++) begin
            p = p * 10;
            b[i] = (v < p);
        end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is at posedge+#1; returns at the posedge+#1 after acceptance.
    task automatic start(input logic [31:0] v);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("ready_wait", 64'(k < 100), 64'd1);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        chk("busy_after_accept", 64'(in_ready), 64'd0);
    endtask

    task automatic wait_done(input int lat0, input logic [31:0] v);
        int lat;
        lat = lat0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 100);
        chk("latency", 64'(lat), 64'd32);
        chk("bcd", 64'(bcd), 64'(ref_bcd(64'(v))));
        chk("ovf", 64'(ovf), 64'(ref_ovf(64'(v))));
`ifdef BCD_BLANK_EN
        chk("blank", 64'(blank), 64'(ref_blank(64'(v))));
`endif
        @(posedge clk);
        #1;
        chk("pulse_width", 64'(out_valid), 64'd0);
        chk("ready_after", 64'(in_ready), 64'd1);
    endtask

    task automatic convert(input logic [31:0] v);
        start(v);
        wait_done(0, v);
    endtask

    initial begin
        int ov_cnt;
        logic [31:0] v;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_bcd", 64'(bcd), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
`ifdef BCD_BLANK_EN
        chk("rst_blank", 64'(blank), 64'hFE);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        convert(32'd0);
        convert(32'd12345678);
        convert(32'd99999999);
        convert(32'd100000000);
        convert(32'hFFFFFFFF);
        convert(32'd305);
        convert(32'd9);
        convert(32'd10);

        // Requests while busy are ignored; held outputs stay put.
        start(32'd42);
        for (int i = 1; i <= 20; i++) begin
            in_valid = 1'b1;
            in_data  = 32'd7;
            if (i == 5) begin
                chk("busy_ignore_ready", 64'(in_ready), 64'd0);
                chk("hold_bcd", 64'(bcd), 64'(ref_bcd(64'd10)));
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_done(20, 32'd42);

        // Reset in the middle of a conversion.
        start(32'd555);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_bcd", 64'(bcd), 64'd0);
        chk("abort_ovf", 64'(ovf), 64'd0);
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_ready", 64'(in_ready), 64'd1);
`ifdef BCD_BLANK_EN
        chk("abort_blank", 64'(blank), 64'hFE);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ov_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) ov_cnt++;
        end
        chk("abort_no_valid", 64'(ov_cnt), 64'd0);

        // Random values, some restricted to the non-overflow range.
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) v = $urandom;
            else v = $urandom_range(99999999, 0);
            convert(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
